pwm_timebase_multi: RTL and testbench

- Parametrised successor to the free-running rover counter. Prescaled timebase with programmable period, plus N compare channels that produce PWM drive for the motor H-bridges.
- Duty and period updates are double-buffered and applied only at period wrap, so motor drive never glitches mid-cycle.
- Sits between the control/register logic and the motor driver pins. Also exports the raw count for current-sense sampling alignment.

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_prescaler.sv | 25 ++
 rtl/pwm_timebase_multi.sv | 113 +++++++++++
 tb/tb_pwm_timebase_multi.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared count type, duty constants and the per-channel duty slice helper
// for the PWM timebase family.
package pwm_pkg;
    localparam int PWM_CNT_W    = 20;
    localparam int PWM_NUM_CH   = 2;
    localparam int PWM_DUTY_OFF = 0;

    typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;

    function automatic pwm_cnt_t pwm_duty_slice(input logic [PWM_NUM_CH*PWM_CNT_W-1:0] duty, input int ch);
        return duty[ch*PWM_CNT_W +: PWM_CNT_W];
    endfunction
endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divides the clock by PRESCALE into a one-cycle tick; held at zero
// while disabled so a restart always begins a full prescale interval.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 1,
    parameter int PS_W     = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q, ps_d;

    assign tick = enable && (ps_q == PS_LAST);
    assign ps_d = (!enable || tick) ? '0 : ps_q + PS_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) ps_q <= '0;
        else          ps_q <= ps_d;
    end
endmodule

// File: rtl/pwm_timebase_multi.sv
// pwm_timebase_multi: prescaled timebase with double-buffered period/duty and NUM_CH
// compare channels. Define PWM_CENTER_ALIGNED_EN for up/down (center-aligned) counting.
module pwm_timebase_multi
    import pwm_pkg::*;
#(
    parameter int CNT_W    = 20,
    parameter int NUM_CH   = 2,
    parameter int PRESCALE = 1,
    parameter int PS_W     = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [CNT_W-1:0]        period,
    input  logic [NUM_CH*CNT_W-1:0] duty,
    input  logic                    load,
    output logic [CNT_W-1:0]        counter,
    output logic                    wrap,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    load_pending
);
    logic              tick, turn, wrap_now, take_in, take_sh;
    logic              wrap_q, wrap_d, pend_q, pend_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, step;
    logic [CNT_W-1:0]  aper_q, aper_d, sper_q, sper_d;
    logic [CNT_W-1:0]  duty_in [NUM_CH];
    logic [CNT_W-1:0]  aduty_q [NUM_CH];
    logic [CNT_W-1:0]  aduty_d [NUM_CH];
    logic [CNT_W-1:0]  sduty_q [NUM_CH];
    logic [CNT_W-1:0]  sduty_d [NUM_CH];
    logic [NUM_CH-1:0] pwm_q, pwm_d;

    pwm_prescaler #(.PRESCALE(PRESCALE), .PS_W(PS_W)) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .tick    (tick)
    );

    assign turn = cnt_q == aper_q;

`ifdef PWM_CENTER_ALIGNED_EN
    logic dir_q, dir_d;

    // dir_q = 1 while counting down; a zero period never leaves the up state
    assign step  = (dir_q || turn) ? ((cnt_q == '0) ? '0 : cnt_q - CNT_W'(1)) : cnt_q + CNT_W'(1);
    assign dir_d = (!enable || (tick && step == '0)) ? 1'b0 : (tick && turn) ? 1'b1 : dir_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) dir_q <= 1'b0;
        else          dir_q <= dir_d;
    end
`else
    assign step = turn ? '0 : cnt_q + CNT_W'(1);
`endif

    // The counter never exceeds the active period, so step only hits 0 at a wrap
    assign wrap_now = tick && (step == '0);
    assign cnt_d    = !enable ? '0 : tick ? step : cnt_q;
    assign wrap_d   = enable && wrap_now;

    // While halted there is no cycle to protect, so loads go straight to active
    assign take_in = load && (wrap_now || !enable);
    assign take_sh = !load && pend_q && (wrap_now || !enable);
    assign aper_d  = take_in ? period : take_sh ? sper_q : aper_q;
    assign sper_d  = (load && !take_in) ? period : sper_q;
    assign pend_d  = load ? !take_in : (pend_q && !take_sh);

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            aduty_d[c] = take_in ? duty_in[c] : take_sh ? sduty_q[c] : aduty_q[c];
            sduty_d[c] = (load && !take_in) ? duty_in[c] : sduty_q[c];
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        if (CNT_W == PWM_CNT_W && NUM_CH == PWM_NUM_CH) begin : g_pkg
            assign duty_in[i] = pwm_duty_slice(duty, i);
        end else begin : g_raw
            assign duty_in[i] = duty[i*CNT_W +: CNT_W];
        end
        assign pwm_d[i] = enable && (cnt_d < aduty_d[i]);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            pwm_q  <= '0;
            pend_q <= 1'b0;
            aper_q <= '1;
            sper_q <= '1;
            for (int c = 0; c < NUM_CH; c++) begin
                aduty_q[c] <= CNT_W'(PWM_DUTY_OFF);
                sduty_q[c] <= CNT_W'(PWM_DUTY_OFF);
            end
        end else begin
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            pwm_q   <= pwm_d;
            pend_q  <= pend_d;
            aper_q  <= aper_d;
            sper_q  <= sper_d;
            aduty_q <= aduty_d;
            sduty_q <= sduty_d;
        end
    end

    assign counter      = cnt_q;
    assign wrap         = wrap_q;
    assign pwm_out      = pwm_q;
    assign load_pending = pend_q;
endmodule

// File: tb/tb_pwm_timebase_multi.sv
// tb_pwm_timebase_multi: scoreboard bench; a phase-based reference model predicts each
// cycle's outputs for a PRESCALE=1 and a PRESCALE=4 instance driven with shared stimulus.
module tb_pwm_timebase_multi;
    localparam int W    = 20;
    localparam int ALL1 = (1 << W) - 1;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         wrap;
        logic [1:0]   pwm;
        logic         pend;
    } obs_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         ld = 1'b0;
    logic [W-1:0] per = '0, d0 = '0, d1 = '0;
    logic [W-1:0] cnt1, cnt4;
    logic         wrap1, wrap4, pend1, pend4;
    logic [1:0]   pwm1, pwm4;

    int   nchk = 0, nerr = 0;
    obs_t q0[$], q1[$];

    int   ps_of[2] = '{1, 4};
    int   m_pre[2], m_ph[2], m_aper[2], m_sper[2], m_cnt[2];
    int   m_ad[2][2], m_sd[2][2];
    bit   m_pend[2], m_wrap[2];
    bit   [1:0] m_pwm[2];
    logic en_s = 1'b0;

    always #5 clk = ~clk;

    pwm_timebase_multi #(.CNT_W(W), .NUM_CH(2), .PRESCALE(1), .PS_W(8)) dut1 (
        .clock(clk), .reset_n(rst_n), .enable(en), .period(per), .duty({d1, d0}), .load(ld),
        .counter(cnt1), .wrap(wrap1), .pwm_out(pwm1), .load_pending(pend1)
    );

    pwm_timebase_multi #(.CNT_W(W), .NUM_CH(2), .PRESCALE(4), .PS_W(8)) dut4 (
        .clock(clk), .reset_n(rst_n), .enable(en), .period(per), .duty({d1, d0}), .load(ld),
        .counter(cnt4), .wrap(wrap4), .pwm_out(pwm4), .load_pending(pend4)
    );

    // Counter is derived from the tick phase within the current cycle rather than
    // stepped: edge mode is a sawtooth of length P+1, center mode a triangle of 2P.
    task automatic model_step(input int k);
        int len;
        bit tk, wn;
        if (!rst_n) begin
            m_pre[k] = 0; m_ph[k] = 0; m_aper[k] = ALL1; m_sper[k] = ALL1;
            m_ad[k] = '{0, 0}; m_sd[k] = '{0, 0}; m_pend[k] = 0;
            m_cnt[k] = 0; m_wrap[k] = 0; m_pwm[k] = 0;
            return;
        end
        if (!en) begin
            m_pre[k] = 0; m_ph[k] = 0;
            if (ld) begin
                m_aper[k] = int'(per); m_ad[k] = '{int'(d0), int'(d1)}; m_pend[k] = 0;
            end else if (m_pend[k]) begin
                m_aper[k] = m_sper[k]; m_ad[k] = m_sd[k]; m_pend[k] = 0;
            end
            m_cnt[k] = 0; m_wrap[k] = 0; m_pwm[k] = 0;
            return;
        end
        tk = (m_pre[k] == ps_of[k] - 1);
        m_pre[k] = tk ? 0 : m_pre[k] + 1;
`ifdef PWM_CENTER_ALIGNED_EN
        len = (m_aper[k] == 0) ? 1 : 2 * m_aper[k];
`else
        len = m_aper[k] + 1;
`endif
        wn = 0;
        if (tk) begin
            m_ph[k]++;
            if (m_ph[k] == len) begin
                m_ph[k] = 0;
                wn = 1;
            end
        end
        if (ld && wn) begin
            m_aper[k] = int'(per); m_ad[k] = '{int'(d0), int'(d1)}; m_pend[k] = 0;
        end else if (ld) begin
            m_sper[k] = int'(per); m_sd[k] = '{int'(d0), int'(d1)}; m_pend[k] = 1;
        end else if (wn && m_pend[k]) begin
            m_aper[k] = m_sper[k]; m_ad[k] = m_sd[k]; m_pend[k] = 0;
        end
`ifdef PWM_CENTER_ALIGNED_EN
        m_cnt[k] = (m_ph[k] <= m_aper[k]) ? m_ph[k] : 2 * m_aper[k] - m_ph[k];
`else
        m_cnt[k] = m_ph[k];
`endif
        m_wrap[k] = wn;
        for (int c = 0; c < 2; c++) m_pwm[k][c] = (m_cnt[k] < m_ad[k][c]);
    endtask

    function automatic obs_t model_obs(input int k);
        obs_t e;
        e.cnt  = W'(m_cnt[k]);
        e.wrap = m_wrap[k];
        e.pwm  = m_pwm[k];
        e.pend = m_pend[k];
        return e;
    endfunction

    task automatic drive(input logic r, input logic e, input logic l, input int p, input int a, input int b);
        @(negedge clk);
        rst_n = r; en = e; ld = l;
        if (l) begin
            per = W'(p); d0 = W'(a); d1 = W'(b);
        end
        model_step(0);
        model_step(1);
        q0.push_back(model_obs(0));
        q1.push_back(model_obs(1));
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, en_s, 1'b0, 0, 0, 0);
    endtask

    task automatic ldv(input int p, input int a, input int b);
        drive(1'b1, en_s, 1'b1, p, a, b);
    endtask

    task automatic run_until(input int target);
        for (int n = 0; n < 300 && m_cnt[0] != target; n++) idle(1);
        if (m_cnt[0] != target) begin
            nchk++;
            nerr++;
            $display("FAIL wait_cnt model counter=%0d required=%0d", m_cnt[0], target);
        end
    endtask

    task automatic check_obs(input int k, input obs_t got, input obs_t exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL obs_dut%0d t=%0t got cnt=%0d wrap=%0b pwm=%b pend=%0b required cnt=%0d wrap=%0b pwm=%b pend=%0b",
                     ps_of[k], $time, got.cnt, got.wrap, got.pwm, got.pend, exp.cnt, exp.wrap, exp.pwm, exp.pend);
        end
    endtask

    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check_obs(0, {cnt1, wrap1, pwm1, pend1}, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check_obs(1, {cnt4, wrap4, pwm4, pend4}, e);
            end
        end
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
        // period 9, duty {3,7}, loaded while halted so it is active at start
        drive(1'b1, 1'b0, 1'b1, 9, 3, 7);
        idle(1);
        en_s = 1'b1;
        idle(30);
        run_until(4);
        ldv(9, 8, 7);
        idle(25);
        ldv(9, 0, 10);
        idle(45);
        ldv(0, 1, 1);
        idle(60);
        ldv(3, 1, 2);
        idle(60);
        ldv(9, 3, 7);
        idle(50);
        run_until(2);
        ldv(5, 2, 4);
        run_until(6);
        en_s = 1'b0;
        idle(2);
        en_s = 1'b1;
        idle(30);
        run_until(1);
        ldv(7, 1, 6);
        run_until(5);
        drive(1'b0, en_s, 1'b0, 0, 0, 0);
        #1;
        nchk++;
        if (cnt1 !== '0 || pwm1 !== '0 || pend1 !== 1'b0 || wrap1 !== 1'b0) begin
            nerr++;
            $display("FAIL async_reset got cnt=%0d pwm=%b pend=%0b wrap=%0b required all zero", cnt1, pwm1, pend1, wrap1);
        end
        drive(1'b0, en_s, 1'b0, 0, 0, 0);
        idle(30);
        en_s = 1'b0;
        ldv(9, 3, 7);
        idle(1);
        en_s = 1'b1;
        for (int n = 0; n < 600; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                en_s = ~en_s;
                idle(1);
            end else if (en_s && r < 15) begin
                ldv(int'($urandom_range(0, 12)), int'($urandom_range(0, 14)), int'($urandom_range(0, 14)));
            end else begin
                idle(1);
            end
        end
        idle(2);
        repeat (2) @(posedge clk);
        #3;
        nchk++;
        if (q0.size() != 0 || q1.size() != 0) begin
            nerr++;
            $display("FAIL drain got pending=%0d/%0d required 0/0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
